// File: rtl/regfile_pkg.sv
// Shared constants for the integer register file: FSM state encoding, zero-register
// address and the default geometry used by the core top level.
package regfile_pkg;

    localparam logic RF_ST_CLEAR = 1'b0;
    localparam logic RF_ST_READY = 1'b1;

    localparam int REG_ZERO = 0;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    typedef enum logic {
        ST_CLEAR = RF_ST_CLEAR,
        ST_READY = RF_ST_READY
    } rf_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: sweeps every register address once, then raises ready.
// Latency: ready rises on the NREGS-th posedge after reset release.
// Backpressure: none; the owner must ignore writes/pending while ready is low.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          ready_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    rf_state_e     state_q;
    logic [AW-1:0] clr_cnt_q;
    logic          ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign clr_we_o   = (state_q == ST_CLEAR);
    assign clr_addr_o = clr_cnt_q;

endmodule : regfile_clear_seq

// File: rtl/regfile_2r1w.sv
// Register file, 2 combinational reads / 1 synchronous write, zero reg + pending scoreboard.
// Latency: writes visible the cycle after the edge; same cycle when REGFILE_BYPASS_EN is defined.
// Backpressure: ready low during the post-reset clear sweep; writes and pend_set are dropped.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int AW       = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic            rs1_pend_o,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            rs2_pend_o,
    input  logic            we_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic            pend_set_i,
    input  logic [AW-1:0]   pend_addr_i,
    output logic            ready_o
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    logic          ready;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    logic          wr_ok;
    logic          pend_ok;
    logic [AW-1:0] rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic          rd_pend [2];

    // Addresses that may hold state: in range and not the hardwired zero register.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !(ZERO_REG && (int'(a) == REG_ZERO));
    endfunction

    regfile_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready_o    (ready),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign wr_ok   = ready && we_i && addr_live(wr_addr_i);
    assign pend_ok = ready && pend_set_i && addr_live(pend_addr_i);

    // Storage is not reset; the clear sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs_q[clr_addr] <= '0;
        end else if (wr_ok) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Set is applied after clear so a new producer on the same address wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[wr_addr_i] = 1'b0;
        end
        if (pend_ok) begin
            pend_d[pend_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign rd_addr[0] = rs1_addr_i;
    assign rd_addr[1] = rs2_addr_i;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic byp_hit;
`ifdef REGFILE_BYPASS_EN
            byp_hit = wr_ok && (wr_addr_i == rd_addr[p]);
`else
            byp_hit = 1'b0;
`endif
            rd_data[p] = '0;
            rd_pend[p] = 1'b0;
            if (ready && addr_live(rd_addr[p])) begin
                rd_data[p] = byp_hit ? wr_data_i : regs_q[rd_addr[p]];
                rd_pend[p] = !byp_hit && pend_q[rd_addr[p]];
            end
        end
    end

    assign rs1_data_o = rd_data[0];
    assign rs1_pend_o = rd_pend[0];
    assign rs2_data_o = rd_data[1];
    assign rs2_pend_o = rd_pend[1];
    assign ready_o    = ready;

endmodule : regfile_2r1w
